// File: rtl/axi_tagctrl_tagc_arb.sv
// Purpose: shares one tag cache port between the read unit (idx 0) and the write unit (idx 1).
// Latency: zero cycles on both paths; request and response steering are purely combinational.
// Backpressure: a grant is held until it is accepted; requests stall while the routing FIFO is full.
//
// Ports:
//   clk_i, rst_ni                         clock, async active-low reset
//   rd_req_* / wr_req_*                   requester request channels (valid/ready)
//   rd_rsp_* / wr_rsp_*                   requester response channels (valid/ready)
//   tagc_req_* / tagc_rsp_*               shared tag cache request/response channels
//   outstanding_o                         routing FIFO occupancy
//   err_unexp_rsp_o                       sticky: response arrived with nothing outstanding
module axi_tagctrl_tagc_arb #(
  parameter int unsigned MaxOutstanding = 4,
  parameter type tagc_req_t = logic,
  parameter type tagc_rsp_t = logic
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  tagc_req_t                           rd_req_i,
  input  logic                                rd_req_valid_i,
  output logic                                rd_req_ready_o,
  output tagc_rsp_t                           rd_rsp_o,
  output logic                                rd_rsp_valid_o,
  input  logic                                rd_rsp_ready_i,
  input  tagc_req_t                           wr_req_i,
  input  logic                                wr_req_valid_i,
  output logic                                wr_req_ready_o,
  output tagc_rsp_t                           wr_rsp_o,
  output logic                                wr_rsp_valid_o,
  input  logic                                wr_rsp_ready_i,
  output tagc_req_t                           tagc_req_o,
  output logic                                tagc_req_valid_o,
  input  logic                                tagc_req_ready_i,
  input  tagc_rsp_t                           tagc_rsp_i,
  input  logic                                tagc_rsp_valid_i,
  output logic                                tagc_rsp_ready_o,
  output logic [$clog2(MaxOutstanding):0]     outstanding_o,
  output logic                                err_unexp_rsp_o
);

  localparam int unsigned CntW = $clog2(MaxOutstanding) + 1;
  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

  // Arbitration state
  logic last_q, last_d;
  logic lock_q, lock_d;
  logic lock_idx_q, lock_idx_d;
  logic err_q, err_d;

  // Routing FIFO of source indices
  logic            mem_q [MaxOutstanding];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic full, empty, src;
  logic gnt_vld, gnt_idx, gnt_req_vld;
  logic push, pop;

  assign full  = (cnt_q == CntW'(MaxOutstanding));
  assign empty = (cnt_q == '0);
  assign src   = mem_q[rd_ptr_q];

  // Grant selection; a held grant overrides everything else.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = 1'b0;
    if (lock_q) begin
      gnt_vld = 1'b1;
      gnt_idx = lock_idx_q;
    end else if (rd_req_valid_i && !wr_req_valid_i) begin
      gnt_vld = 1'b1;
      gnt_idx = 1'b0;
    end else if (wr_req_valid_i && !rd_req_valid_i) begin
      gnt_vld = 1'b1;
      gnt_idx = 1'b1;
    end else if (rd_req_valid_i && wr_req_valid_i) begin
      gnt_vld = 1'b1;
      gnt_idx = ~last_q;
    end
  end

  // Request path; full uses the registered count, so a same-cycle pop does not unblock.
  assign gnt_req_vld      = gnt_idx ? wr_req_valid_i : rd_req_valid_i;
  assign tagc_req_valid_o = !full && gnt_vld && gnt_req_vld;
  assign tagc_req_o       = gnt_idx ? wr_req_i : rd_req_i;
  assign rd_req_ready_o   = !full && gnt_vld && !gnt_idx && tagc_req_ready_i;
  assign wr_req_ready_o   = !full && gnt_vld &&  gnt_idx && tagc_req_ready_i;
  assign push             = tagc_req_valid_o && tagc_req_ready_i;

  // Response path; with nothing outstanding every beat is accepted and dropped.
  assign rd_rsp_o         = tagc_rsp_i;
  assign wr_rsp_o         = tagc_rsp_i;
  assign rd_rsp_valid_o   = !empty && !src && tagc_rsp_valid_i;
  assign wr_rsp_valid_o   = !empty &&  src && tagc_rsp_valid_i;
  assign tagc_rsp_ready_o = empty ? 1'b1 : (src ? wr_rsp_ready_i : rd_rsp_ready_i);
  assign pop              = !empty && tagc_rsp_valid_i && tagc_rsp_ready_o;

  always_comb begin
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    last_d     = last_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    err_d      = err_q | (empty && tagc_rsp_valid_i);
    if (push) begin
      lock_d   = 1'b0;
      last_d   = gnt_idx;
      wr_ptr_d = (wr_ptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : wr_ptr_q + PtrW'(1);
    end else if (tagc_req_valid_o) begin
      lock_d     = 1'b1;
      lock_idx_d = gnt_idx;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : rd_ptr_q + PtrW'(1);
    end
    cnt_d = cnt_q + CntW'(push) - CntW'(pop);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q     <= 1'b1;
      lock_q     <= 1'b0;
      lock_idx_q <= 1'b0;
      err_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      for (int i = 0; i < MaxOutstanding; i++) mem_q[i] <= 1'b0;
    end else begin
      last_q     <= last_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      err_q      <= err_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      if (push) mem_q[wr_ptr_q] <= gnt_idx;
    end
  end

  assign outstanding_o   = cnt_q;
  assign err_unexp_rsp_o = err_q;

endmodule
